timer_16bit_controller: RTL and testbench

Sequencing controller for Timer/Counter1, the 16-bit timer: prescaler tick generation, count/clear sequencing, compare-match and overflow detection, interrupt flag/request handling, and the atomic 16-bit TEMP-register access protocol on the 8-bit I/O bus. It owns TCNT1, OCR1A, TCCR1B, TIMSK and TIFR state and sits between the CPU I/O decoder and the interrupt controller.

---
 rtl/timer_16bit_controller_if.sv | 24 ++
 rtl/timer_16bit_controller.sv | 175 +++++++++++++++++
 tb/tb_timer_16bit_controller.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/timer_16bit_controller_if.sv
// I/O bus, external clock pin and interrupt handshake between the CPU side
// and the 16-bit timer controller.
interface timer_16bit_controller_if;
    logic [5:0] io_addr;
    logic       io_wr;
    logic       io_rd;
    logic [7:0] io_wdata;
    logic [7:0] io_rdata;
    logic       t1_pin;
    logic       int_ack_ovf;
    logic       int_ack_cmp;
    logic       irq_ovf;
    logic       irq_cmp;

    modport master (
        output io_addr, io_wr, io_rd, io_wdata, t1_pin, int_ack_ovf, int_ack_cmp,
        input  io_rdata, irq_ovf, irq_cmp
    );

    modport slave (
        input  io_addr, io_wr, io_rd, io_wdata, t1_pin, int_ack_ovf, int_ack_cmp,
        output io_rdata, irq_ovf, irq_cmp
    );
endinterface

// File: rtl/timer_16bit_controller.sv
// Timer/Counter1 sequencing: prescaler, count/clear, compare/overflow flags and TEMP access.
// Optional external clock source on t1_pin is enabled by defining TIMER1_EXT_CLK_EN.
module timer_16bit_controller #(
    parameter int PRESCALE_W = 10
) (
    input  logic                         sysClock,
    input  logic                         system_reset,
    timer_16bit_controller_if.slave      bus
);
    localparam logic [5:0] ADDR_OCR1AL = 6'h2A;
    localparam logic [5:0] ADDR_OCR1AH = 6'h2B;
    localparam logic [5:0] ADDR_TCNT1L = 6'h2C;
    localparam logic [5:0] ADDR_TCNT1H = 6'h2D;
    localparam logic [5:0] ADDR_TCCR1B = 6'h2E;
    localparam logic [5:0] ADDR_TIFR   = 6'h38;
    localparam logic [5:0] ADDR_TIMSK  = 6'h39;

    logic [15:0]           tcnt_r;
    logic [15:0]           ocr_r;
    logic [7:0]            temp_r;
    logic [3:0]            tccr_r;
    logic [7:0]            timsk_r;
    logic                  ocf_r;
    logic                  tov_r;
    logic                  block_r;
    logic [PRESCALE_W-1:0] prescaler_r;
    logic [7:0]            rdata_r;

    logic        ext_rise_s;
    logic        ext_fall_s;
    logic        tick_s;
    logic        match_s;
    logic        tcnt_wr_s;
    logic        tifr_wr_s;
    logic [15:0] tcnt_next_s;
    logic        block_next_s;
    logic        ovf_set_s;
    logic        cmp_set_s;
    logic        ocf_clr_s;
    logic        tov_clr_s;

`ifdef TIMER1_EXT_CLK_EN
    logic t1_meta_r;
    logic t1_sync_r;
    logic t1_prev_r;

    // Two-flop synchroniser for t1_pin plus a delayed copy for edge detection.
    always_ff @(posedge sysClock) begin
        if (system_reset) begin
            t1_meta_r <= 1'b0;
            t1_sync_r <= 1'b0;
            t1_prev_r <= 1'b0;
        end else begin
            t1_meta_r <= bus.t1_pin;
            t1_sync_r <= t1_meta_r;
            t1_prev_r <= t1_sync_r;
        end
    end

    assign ext_rise_s = t1_sync_r & ~t1_prev_r;
    assign ext_fall_s = ~t1_sync_r & t1_prev_r;
`else
    assign ext_rise_s = 1'b0;
    assign ext_fall_s = 1'b0;
`endif

    assign tcnt_wr_s = bus.io_wr && (bus.io_addr == ADDR_TCNT1L);
    assign tifr_wr_s = bus.io_wr && (bus.io_addr == ADDR_TIFR);
    assign match_s   = (tcnt_r == ocr_r) && !block_r;

    // Clock-select decode; prescaler taps assume PRESCALE_W >= 10.
    always_comb begin
        tick_s = 1'b0;
        case (tccr_r[2:0])
            3'd0:    tick_s = 1'b0;
            3'd1:    tick_s = 1'b1;
            3'd2:    tick_s = &prescaler_r[2:0];
            3'd3:    tick_s = &prescaler_r[5:0];
            3'd4:    tick_s = &prescaler_r[7:0];
            3'd5:    tick_s = &prescaler_r[9:0];
            3'd6:    tick_s = ext_fall_s;
            3'd7:    tick_s = ext_rise_s;
            default: tick_s = 1'b0;
        endcase
    end

    // Counter next state: a CPU write beats a tick; the write arms a one-tick compare block.
    always_comb begin
        tcnt_next_s  = tcnt_r;
        block_next_s = block_r;
        ovf_set_s    = 1'b0;
        cmp_set_s    = 1'b0;
        if (tcnt_wr_s) begin
            tcnt_next_s  = {temp_r, bus.io_wdata};
            block_next_s = 1'b1;
        end else if (tick_s) begin
            block_next_s = 1'b0;
            if (tccr_r[3] && match_s) begin
                tcnt_next_s = 16'h0000;
                cmp_set_s   = 1'b1;
            end else if (tcnt_r == 16'hFFFF) begin
                tcnt_next_s = 16'h0000;
                ovf_set_s   = 1'b1;
                cmp_set_s   = match_s;
            end else begin
                tcnt_next_s = tcnt_r + 16'd1;
                cmp_set_s   = match_s;
            end
        end else begin
            tcnt_next_s = tcnt_r;
        end
    end

    assign ocf_clr_s = (tifr_wr_s && bus.io_wdata[4]) || bus.int_ack_cmp;
    assign tov_clr_s = (tifr_wr_s && bus.io_wdata[2]) || bus.int_ack_ovf;

    // Register file, flags, TEMP and prescaler state.
    always_ff @(posedge sysClock) begin
        if (system_reset) begin
            tcnt_r      <= 16'h0000;
            ocr_r       <= 16'h0000;
            temp_r      <= 8'h00;
            tccr_r      <= 4'h0;
            timsk_r     <= 8'h00;
            ocf_r       <= 1'b0;
            tov_r       <= 1'b0;
            block_r     <= 1'b0;
            prescaler_r <= '0;
        end else begin
            prescaler_r <= prescaler_r + 1'b1;
            tcnt_r      <= tcnt_next_s;
            block_r     <= block_next_s;
            ocf_r       <= (ocf_r & ~ocf_clr_s) | cmp_set_s;
            tov_r       <= (tov_r & ~tov_clr_s) | ovf_set_s;
            if (bus.io_wr && (bus.io_addr == ADDR_OCR1AL)) begin
                ocr_r <= {temp_r, bus.io_wdata};
            end
            if (bus.io_wr && (bus.io_addr == ADDR_TCCR1B)) begin
                tccr_r <= bus.io_wdata[3:0];
            end
            if (bus.io_wr && (bus.io_addr == ADDR_TIMSK)) begin
                timsk_r <= bus.io_wdata;
            end
            if (bus.io_wr && ((bus.io_addr == ADDR_TCNT1H) || (bus.io_addr == ADDR_OCR1AH))) begin
                temp_r <= bus.io_wdata;
            end else if (bus.io_rd && (bus.io_addr == ADDR_TCNT1L)) begin
                temp_r <= tcnt_r[15:8];
            end
        end
    end

    // Registered read data, held between reads.
    always_ff @(posedge sysClock) begin
        if (system_reset) begin
            rdata_r <= 8'h00;
        end else if (bus.io_rd) begin
            case (bus.io_addr)
                ADDR_TCNT1L: rdata_r <= tcnt_r[7:0];
                ADDR_TCNT1H: rdata_r <= temp_r;
                ADDR_OCR1AL: rdata_r <= ocr_r[7:0];
                ADDR_OCR1AH: rdata_r <= ocr_r[15:8];
                ADDR_TCCR1B: rdata_r <= {4'h0, tccr_r};
                ADDR_TIMSK:  rdata_r <= timsk_r;
                ADDR_TIFR:   rdata_r <= {3'b000, ocf_r, 1'b0, tov_r, 2'b00};
                default:     rdata_r <= 8'h00;
            endcase
        end else begin
            rdata_r <= rdata_r;
        end
    end

    assign bus.io_rdata = rdata_r;
    assign bus.irq_ovf  = tov_r & timsk_r[2];
    assign bus.irq_cmp  = ocf_r & timsk_r[4];
endmodule

// File: tb/tb_timer_16bit_controller.sv
// Directed self-checking bench for timer_16bit_controller: register access,
// overflow, CTC, atomic TEMP reads, collisions, external clock and reset.
module tb_timer_16bit_controller;
    logic clk;
    logic rst;
    int   total;
    int   bad;
    int   n;
    logic [7:0] d;
    logic found;

    timer_16bit_controller_if bus ();

    timer_16bit_controller #(.PRESCALE_W(10)) dut (
        .sysClock     (clk),
        .system_reset (rst),
        .bus          (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // All bus tasks start and end at a falling edge.
    task automatic wr(input logic [5:0] a, input logic [7:0] v);
        bus.io_addr  = a;
        bus.io_wdata = v;
        bus.io_wr    = 1'b1;
        @(negedge clk);
        bus.io_wr    = 1'b0;
    endtask

    task automatic rd(input logic [5:0] a, output logic [7:0] v);
        bus.io_addr = a;
        bus.io_rd   = 1'b1;
        @(negedge clk);
        bus.io_rd   = 1'b0;
        v = bus.io_rdata;
    endtask

    task automatic wait_to(input int target);
        while (n < target) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        n     = 0;
        rst   = 1'b1;
        bus.io_addr = 6'h00;
        bus.io_wr = 1'b0;
        bus.io_rd = 1'b0;
        bus.io_wdata = 8'h00;
        bus.t1_pin = 1'b0;
        bus.int_ack_ovf = 1'b0;
        bus.int_ack_cmp = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        chk("rst_rdata", {8'h00, bus.io_rdata}, 16'h0000);
        chk("rst_irq", {14'h0, bus.irq_ovf, bus.irq_cmp}, 16'h0000);
        rd(6'h2C, d); chk("rst_tcntl", {8'h00, d}, 16'h0000);
        rd(6'h2B, d); chk("rst_ocrh", {8'h00, d}, 16'h0000);
        rd(6'h2E, d); chk("rst_tccr", {8'h00, d}, 16'h0000);
        rd(6'h38, d); chk("rst_tifr", {8'h00, d}, 16'h0000);

        wr(6'h2E, 8'hFF); rd(6'h2E, d); chk("tccr_mask", {8'h00, d}, 16'h000F);
        wr(6'h2E, 8'h00);
        wr(6'h39, 8'hA5); rd(6'h39, d); chk("timsk_rb", {8'h00, d}, 16'h00A5);
        rd(6'h10, d); chk("unmapped", {8'h00, d}, 16'h0000);
        wr(6'h38, 8'hFF); rd(6'h38, d); chk("tifr_w1c_idle", {8'h00, d}, 16'h0000);

        // Overflow from 0xFFFE at CS=1
        wr(6'h2B, 8'h80); wr(6'h2A, 8'h00);
        wr(6'h2D, 8'hFF); wr(6'h2C, 8'hFE);
        wr(6'h39, 8'h04);
        wr(6'h2E, 8'h01);
        @(negedge clk); @(negedge clk);
        chk("ovf_irq_set", {15'h0, bus.irq_ovf}, 16'h0001);
        rd(6'h2C, d); chk("ovf_tcntl", {8'h00, d}, 16'h0000);
        rd(6'h2D, d); chk("ovf_tcnth", {8'h00, d}, 16'h0000);
        rd(6'h38, d); chk("ovf_tifr", {8'h00, d}, 16'h0004);
        wr(6'h38, 8'h04);
        chk("ovf_irq_clr", {15'h0, bus.irq_ovf}, 16'h0000);
        rd(6'h38, d); chk("ovf_tifr_clr", {8'h00, d}, 16'h0000);
        wr(6'h2E, 8'h00);

        // Atomic read while counting
        wr(6'h2D, 8'h12); wr(6'h2C, 8'hFF);
        wr(6'h2E, 8'h01);
        rd(6'h2C, d); chk("atom_low", {8'h00, d}, 16'h00FF);
        rd(6'h2D, d); chk("atom_high", {8'h00, d}, 16'h0012);
        rd(6'h2C, d); chk("atom_advanced", {8'h00, d}, 16'h0001);
        wr(6'h2E, 8'h00);

        // CTC at /8 with OCR1A=3
        wr(6'h2D, 8'h00); wr(6'h2C, 8'h00);
        wr(6'h2B, 8'h00); wr(6'h2A, 8'h03);
        wr(6'h38, 8'h14);
        wr(6'h39, 8'h10);
        wr(6'h2E, 8'h0A);
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            if (bus.irq_cmp) found = 1'b1;
        end
        chk("ctc_first_set", {15'h0, found}, 16'h0001);
        n = 0;
        rd(6'h2C, d); n++; chk("ctc_cnt0", {8'h00, d}, 16'h0000);
        bus.int_ack_cmp = 1'b1;
        @(negedge clk); n++;
        bus.int_ack_cmp = 1'b0;
        chk("ctc_ack_clr", {15'h0, bus.irq_cmp}, 16'h0000);
        wait_to(9);  rd(6'h2C, d); n++; chk("ctc_cnt1", {8'h00, d}, 16'h0001);
        wait_to(17); rd(6'h2C, d); n++; chk("ctc_cnt2", {8'h00, d}, 16'h0002);
        wait_to(25); rd(6'h2C, d); n++; chk("ctc_cnt3", {8'h00, d}, 16'h0003);
        while (!bus.irq_cmp && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("ctc_period", n[15:0], 16'd32);
        rd(6'h2C, d); chk("ctc_wrap", {8'h00, d}, 16'h0000);
        wr(6'h2E, 8'h00);
        wr(6'h38, 8'h14);

        // Flag set and TIFR clear on the same edge
        wr(6'h2D, 8'hFF); wr(6'h2C, 8'hFF);
        wr(6'h2E, 8'h01);
        wr(6'h38, 8'h04);
        rd(6'h38, d); chk("coll_flag_kept", {8'h00, d}, 16'h0004);
        wr(6'h2E, 8'h00);
        wr(6'h38, 8'h04);
        rd(6'h38, d); chk("coll_flag_clr", {8'h00, d}, 16'h0000);

        // TCNT write and tick on the same edge; next tick's match is blocked
        wr(6'h2B, 8'h00); wr(6'h2A, 8'h50);
        wr(6'h2E, 8'h01);
        wr(6'h2D, 8'h00); wr(6'h2C, 8'h50);
        rd(6'h2C, d); chk("coll_wr_held", {8'h00, d}, 16'h0050);
        rd(6'h38, d); chk("coll_no_match", {8'h00, d}, 16'h0000);
        wr(6'h2E, 8'h00);

        // Normal-mode match on the pre-increment value
        wr(6'h38, 8'h14);
        wr(6'h2D, 8'h00); wr(6'h2C, 8'h4F);
        wr(6'h2E, 8'h01);
        @(negedge clk); @(negedge clk);
        chk("match_irq", {15'h0, bus.irq_cmp}, 16'h0001);
        rd(6'h38, d); chk("match_tifr", {8'h00, d}, 16'h0010);
        wr(6'h2E, 8'h00);
        wr(6'h38, 8'h14);

        // External clock at CS=7
        wr(6'h2D, 8'h00); wr(6'h2C, 8'h00);
        wr(6'h2E, 8'h07);
        repeat (3) begin
            bus.t1_pin = 1'b1;
            repeat (4) @(negedge clk);
            bus.t1_pin = 1'b0;
            repeat (4) @(negedge clk);
        end
        repeat (4) @(negedge clk);
        rd(6'h2C, d);
`ifdef TIMER1_EXT_CLK_EN
        chk("ext_clk_cnt", {8'h00, d}, 16'h0003);
`else
        chk("ext_clk_cnt", {8'h00, d}, 16'h0000);
`endif

        // Reset while counting
        wr(6'h2E, 8'h00);
        wr(6'h2D, 8'h12); wr(6'h2C, 8'h34);
        wr(6'h2B, 8'hAB); wr(6'h2A, 8'hCD);
        wr(6'h39, 8'h14);
        wr(6'h2E, 8'h01);
        rd(6'h39, d); chk("pre_rst_timsk", {8'h00, d}, 16'h0014);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_rdata", {8'h00, bus.io_rdata}, 16'h0000);
        rd(6'h2C, d); chk("mid_rst_tcntl", {8'h00, d}, 16'h0000);
        rd(6'h2D, d); chk("mid_rst_tcnth", {8'h00, d}, 16'h0000);
        rd(6'h2B, d); chk("mid_rst_ocrh", {8'h00, d}, 16'h0000);
        rd(6'h2A, d); chk("mid_rst_ocrl", {8'h00, d}, 16'h0000);
        rd(6'h2E, d); chk("mid_rst_tccr", {8'h00, d}, 16'h0000);
        rd(6'h39, d); chk("mid_rst_timsk", {8'h00, d}, 16'h0000);
        rd(6'h38, d); chk("mid_rst_tifr", {8'h00, d}, 16'h0000);
        repeat (5) @(negedge clk);
        rd(6'h2C, d); chk("mid_rst_stopped", {8'h00, d}, 16'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
